// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: arm/disarm, match-minute edge detection,
// ring / snooze / auto-stop sequencing and the ringing LED blink.
module alarm_ctrl #(
    parameter int TIME_0_1S  = 5_000_000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] min_l,
    input  logic [3:0] min_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] hour_h,
    input  logic [3:0] alarm_min_l,
    input  logic [3:0] alarm_min_h,
    input  logic [3:0] alarm_hour_l,
    input  logic [3:0] alarm_hour_h,
    input  logic       sec_tick,
    input  logic       key_arm,
    input  logic       key_snooze,
    input  logic       key_stop,
    output logic [1:0] state,
    output logic       armed,
    output logic       ringing,
    output logic [1:0] snooze_left,
    output logic       led
);

    localparam int BW = (TIME_0_1S  > 1) ? $clog2(TIME_0_1S)  : 1;
    localparam int RW = (RING_SEC   > 1) ? $clog2(RING_SEC)   : 1;
    localparam int SW = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;

    localparam logic [BW-1:0] BLINK_LAST = BW'(TIME_0_1S - 1);
    localparam logic [RW-1:0] RING_LAST  = RW'(RING_SEC - 1);
    localparam logic [SW-1:0] SNZ_LAST   = SW'(SNOOZE_SEC - 1);
    localparam logic [1:0]    MAX_LEFT   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] ring_sec_q, ring_sec_d, ring_sec_s;
    logic [SW-1:0] snz_sec_q, snz_sec_d, snz_sec_s;
    logic [1:0]    snooze_left_q, snooze_left_d, snooze_left_s;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          led_q, led_d;
    logic          armed_q, armed_d;
    logic          ringing_q, ringing_d;
    logic          match_dly_q;
    logic          match_s;
    logic          match_rise_s;

    // Only the first cycle of a matching minute may start a ring.
    always_comb begin
        match_s      = (min_l  == alarm_min_l)  && (min_h  == alarm_min_h) &&
                       (hour_l == alarm_hour_l) && (hour_h == alarm_hour_h);
        match_rise_s = match_s & ~match_dly_q;
    end

    // Sequencer: keys first (arm > stop > snooze), then second ticks, then match edge.
    always_comb begin
        state_d       = state_q;
        ring_sec_s    = ring_sec_q;
        snz_sec_s     = snz_sec_q;
        snooze_left_s = snooze_left_q;
        case (state_q)
            ST_DISARMED: begin
                if (key_arm) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_DISARMED;
                end
            end
            ST_ARMED: begin
                if (key_arm) begin
                    state_d = ST_DISARMED;
                end else if (match_rise_s) begin
                    state_d       = ST_RINGING;
                    ring_sec_s    = '0;
                    snooze_left_s = MAX_LEFT;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_RINGING: begin
                if (key_arm) begin
                    state_d = ST_DISARMED;
                end else if (key_stop) begin
                    state_d = ST_ARMED;
                end else if (key_snooze) begin
                    // An exhausted snooze still consumes the cycle's tick.
                    if (snooze_left_q != 2'd0) begin
                        state_d       = ST_SNOOZE;
                        snz_sec_s     = '0;
                        snooze_left_s = snooze_left_q - 2'd1;
                    end else begin
                        state_d = ST_RINGING;
                    end
                end else if (sec_tick) begin
                    if (ring_sec_q == RING_LAST) begin
                        state_d = ST_ARMED;
                    end else begin
                        ring_sec_s = ring_sec_q + RW'(1);
                    end
                end else begin
                    state_d = ST_RINGING;
                end
            end
            ST_SNOOZE: begin
                if (key_arm) begin
                    state_d = ST_DISARMED;
                end else if (key_stop) begin
                    state_d = ST_ARMED;
                end else if (key_snooze) begin
                    state_d = ST_SNOOZE;
                end else if (sec_tick) begin
                    if (snz_sec_q == SNZ_LAST) begin
                        state_d    = ST_RINGING;
                        ring_sec_s = '0;
                        snz_sec_s  = '0;
                    end else begin
                        snz_sec_s = snz_sec_q + SW'(1);
                    end
                end else begin
                    state_d = ST_SNOOZE;
                end
            end
            default: begin
                state_d = ST_DISARMED;
            end
        endcase
    end

    // Outside an alarm event the counters rest at zero and the snooze budget is full.
    always_comb begin
        if ((state_d == ST_DISARMED) || (state_d == ST_ARMED)) begin
            ring_sec_d    = '0;
            snz_sec_d     = '0;
            snooze_left_d = MAX_LEFT;
        end else begin
            ring_sec_d    = ring_sec_s;
            snz_sec_d     = snz_sec_s;
            snooze_left_d = snooze_left_s;
        end
        armed_d   = (state_d != ST_DISARMED);
        ringing_d = (state_d == ST_RINGING);
    end

    // LED lights immediately on ring entry and then toggles every blink period.
    always_comb begin
        if (state_d != ST_RINGING) begin
            led_d       = 1'b0;
            blink_cnt_d = '0;
        end else if (state_q != ST_RINGING) begin
            led_d       = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            led_d       = ~led_q;
            blink_cnt_d = '0;
        end else begin
            led_d       = led_q;
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_DISARMED;
            ring_sec_q    <= '0;
            snz_sec_q     <= '0;
            snooze_left_q <= MAX_LEFT;
            blink_cnt_q   <= '0;
            led_q         <= 1'b0;
            armed_q       <= 1'b0;
            ringing_q     <= 1'b0;
            match_dly_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_sec_q    <= ring_sec_d;
            snz_sec_q     <= snz_sec_d;
            snooze_left_q <= snooze_left_d;
            blink_cnt_q   <= blink_cnt_d;
            led_q         <= led_d;
            armed_q       <= armed_d;
            ringing_q     <= ringing_d;
            match_dly_q   <= match_s;
        end
    end

    assign state       = state_q;
    assign armed       = armed_q;
    assign ringing     = ringing_q;
    assign snooze_left = snooze_left_q;
    assign led         = led_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios followed by random
// key/tick/time/reset traffic, all checked against a behavioural reference model.
module tb_alarm_ctrl;

    localparam int T01 = 4;
    localparam int RS  = 5;
    localparam int SS  = 3;
    localparam int MS  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] min_l, min_h, hour_l, hour_h;
    logic [3:0] alarm_min_l, alarm_min_h, alarm_hour_l, alarm_hour_h;
    logic       sec_tick, key_arm, key_snooze, key_stop;
    logic [1:0] state;
    logic       armed, ringing;
    logic [1:0] snooze_left;
    logic       led;

    always #5 clk = ~clk;

    alarm_ctrl #(
        .TIME_0_1S (T01),
        .RING_SEC  (RS),
        .SNOOZE_SEC(SS),
        .MAX_SNOOZE(MS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .min_l       (min_l),
        .min_h       (min_h),
        .hour_l      (hour_l),
        .hour_h      (hour_h),
        .alarm_min_l (alarm_min_l),
        .alarm_min_h (alarm_min_h),
        .alarm_hour_l(alarm_hour_l),
        .alarm_hour_h(alarm_hour_h),
        .sec_tick    (sec_tick),
        .key_arm     (key_arm),
        .key_snooze  (key_snooze),
        .key_stop    (key_stop),
        .state       (state),
        .armed       (armed),
        .ringing     (ringing),
        .snooze_left (snooze_left),
        .led         (led)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time in hours/minutes, seconds counted up, LED from cycles since ring entry.
    int cur_h, cur_m, al_h, al_m;
    int m_state, m_ring, m_snz, m_left, m_cyc;
    bit m_led, m_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_time(input int h, input int m);
        cur_h  = h;
        cur_m  = m;
        hour_h = 4'(h / 10);
        hour_l = 4'(h % 10);
        min_h  = 4'(m / 10);
        min_l  = 4'(m % 10);
    endtask

    task automatic model_step();
        bit match;
        bit rise;
        int old;
        match  = (cur_h == al_h) && (cur_m == al_m);
        rise   = match && !m_prev;
        old    = m_state;
        m_prev = match;
        if (rst) begin
            m_state = 0; m_ring = 0; m_snz = 0; m_left = MS; m_cyc = 0;
            m_led = 1'b0; m_prev = 1'b0;
            return;
        end
        if (m_state == 0) begin
            if (key_arm) m_state = 1;
        end else if (m_state == 1) begin
            if (key_arm) m_state = 0;
            else if (rise) begin m_state = 2; m_ring = 0; m_left = MS; end
        end else if (m_state == 2) begin
            if (key_arm) m_state = 0;
            else if (key_stop) m_state = 1;
            else if (key_snooze) begin
                if (m_left > 0) begin m_state = 3; m_snz = 0; m_left--; end
            end else if (sec_tick) begin
                m_ring++;
                if (m_ring == RS) m_state = 1;
            end
        end else begin
            if (key_arm) m_state = 0;
            else if (key_stop) m_state = 1;
            else if (!key_snooze && sec_tick) begin
                m_snz++;
                if (m_snz == SS) begin m_state = 2; m_ring = 0; end
            end
        end
        if (m_state < 2) begin m_left = MS; m_ring = 0; m_snz = 0; end
        if (m_state == 2) begin
            m_cyc = (old == 2) ? m_cyc + 1 : 0;
            m_led = ((m_cyc / T01) % 2) == 0;
        end else begin
            m_cyc = 0;
            m_led = 1'b0;
        end
    endtask

    // One clock: model advances with the DUT, outputs compared #1 after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("state",       {30'd0, state},        m_state);
        check("armed",       {31'd0, armed},        (m_state != 0) ? 1 : 0);
        check("ringing",     {31'd0, ringing},      (m_state == 2) ? 1 : 0);
        check("snooze_left", {30'd0, snooze_left},  m_left);
        check("led",         {31'd0, led},          m_led);
        @(negedge clk);
        rst = 1'b0; sec_tick = 1'b0; key_arm = 1'b0; key_snooze = 1'b0; key_stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin sec_tick = 1'b1; cycle(); end
    endtask

    task automatic rematch();
        set_time(6, 59); cycle();
        set_time(7, 0);  cycle();
    endtask

    initial begin
        rst = 1'b1; sec_tick = 1'b0; key_arm = 1'b0; key_snooze = 1'b0; key_stop = 1'b0;
        al_h = 7; al_m = 0;
        alarm_hour_h = 4'd0; alarm_hour_l = 4'd7; alarm_min_h = 4'd0; alarm_min_l = 4'd0;
        set_time(6, 59);
        m_state = 0; m_ring = 0; m_snz = 0; m_left = MS; m_cyc = 0; m_led = 1'b0; m_prev = 1'b0;
        @(negedge clk);
        rst = 1'b1; cycle();
        check("rst_state", {30'd0, state}, 0);
        check("rst_left",  {30'd0, snooze_left}, 2);
        check("rst_led",   {31'd0, led}, 0);

        // 1: arm, minute edge to 07:00 rings, LED holds 4 clk then toggles
        key_arm = 1'b1; cycle();
        check("t1_armed", {30'd0, state}, 1);
        set_time(7, 0); cycle();
        check("t1_ring", {30'd0, state}, 2);
        check("t1_led_on", {31'd0, led}, 1);
        idle(3);
        check("t1_led_hold", {31'd0, led}, 1);
        cycle();
        check("t1_led_toggle", {31'd0, led}, 0);
        idle(4);
        check("t1_led_back", {31'd0, led}, 1);

        // 2: auto-stop after RING_SEC ticks, no re-ring while the time stays 07:00
        ticks(4);
        check("t2_still_ring", {30'd0, state}, 2);
        ticks(1);
        check("t2_autostop", {30'd0, state}, 1);
        check("t2_led_off", {31'd0, led}, 0);
        idle(6);
        check("t2_no_rering", {30'd0, state}, 1);

        // 3: snooze twice, third snooze ignored
        rematch();
        key_snooze = 1'b1; cycle();
        check("t3_snz1", {30'd0, state}, 3);
        check("t3_left1", {30'd0, snooze_left}, 1);
        check("t3_led0", {31'd0, led}, 0);
        ticks(3);
        check("t3_rering1", {30'd0, state}, 2);
        key_snooze = 1'b1; cycle();
        check("t3_left0", {30'd0, snooze_left}, 0);
        ticks(3);
        check("t3_rering2", {30'd0, state}, 2);
        key_snooze = 1'b1; sec_tick = 1'b1; cycle();
        check("t3_snz_ignored", {30'd0, state}, 2);

        // 4: stop beats snooze; arm beats stop
        key_stop = 1'b1; key_snooze = 1'b1; cycle();
        check("t4_stop", {30'd0, state}, 1);
        check("t4_left_reload", {30'd0, snooze_left}, 2);
        rematch();
        key_arm = 1'b1; key_stop = 1'b1; cycle();
        check("t4_disarm", {30'd0, state}, 0);

        // 5: disarmed match discarded; arming mid-minute does not ring
        rematch();
        check("t5_disarmed", {30'd0, state}, 0);
        key_arm = 1'b1; cycle();
        idle(3);
        check("t5_no_ring", {30'd0, state}, 1);
        rematch();
        check("t5_ring", {30'd0, state}, 2);

        // 6: reset dominates in snooze and mid-blink
        key_snooze = 1'b1; cycle();
        ticks(1);
        rst = 1'b1; cycle();
        check("t6_rst_snz", {30'd0, state}, 0);
        check("t6_rst_left", {30'd0, snooze_left}, 2);
        key_arm = 1'b1; cycle();
        rematch();
        idle(2);
        rst = 1'b1; cycle();
        check("t6_rst_blink_state", {30'd0, state}, 0);
        check("t6_rst_blink_led", {31'd0, led}, 0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int r;
            r          = int'($urandom_range(0, 99));
            key_arm    = (r < 3);
            key_stop   = (r >= 3 && r < 6);
            key_snooze = (r >= 6 && r < 14);
            sec_tick   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) < 2) key_stop = 1'b1;
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 2))
                    0: set_time(6, 59);
                    1: set_time(7, 0);
                    default: set_time(7, 1);
                endcase
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
